// File: rtl/mod_down_timer_pkg.sv
// Shared definitions for the mod-N down timer: run-state encoding and standard moduli.
package mod_down_timer_pkg;

  localparam int unsigned STATE_BITS = 2;
  localparam int unsigned MOD_HOUR   = 24;
  localparam int unsigned MOD_MIN    = 60;

  typedef enum logic [STATE_BITS-1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

endpackage

// File: rtl/mod_down_timer_if.sv
// Control and status bundle of one mod-N down timer stage.
interface mod_down_timer_if #(
  parameter int unsigned BITS = 5
);

  logic            tick;
  logic            chain_zero;
  logic            start;
  logic            stop;
  logic            clr;
  logic            load;
  logic [BITS-1:0] load_val;
  logic [BITS-1:0] count_out;
  logic            borrow_out;
  logic            zero;
  logic            running;
  logic            expired;

  modport master (
    output tick, chain_zero, start, stop, clr, load, load_val,
    input  count_out, borrow_out, zero, running, expired
  );

  modport slave (
    input  tick, chain_zero, start, stop, clr, load, load_val,
    output count_out, borrow_out, zero, running, expired
  );

endinterface

// File: rtl/mod_down_timer_core.sv
// Count datapath: saturating load, decrement, wrap to MOD-1 and one-cycle borrow pulse.
module mod_down_timer_core #(
  parameter int unsigned MOD  = 24,
  parameter int unsigned BITS = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load,
  input  logic [BITS-1:0] load_val,
  input  logic            tick_en,
  input  logic            wrap_allow,
  output logic [BITS-1:0] count_out,
  output logic            borrow_out,
  output logic            zero_c
);

  localparam logic [BITS-1:0] TOP = BITS'(MOD - 1);

  logic [BITS-1:0] count_d, count_q;
  logic            borrow_d, borrow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      borrow_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      borrow_q <= borrow_d;
    end
  end

  // Zero is handled explicitly so a decrement below zero is never formed.
  always_comb begin
    count_d  = count_q;
    borrow_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > TOP) ? TOP : load_val;
    end else if (tick_en) begin
      if (count_q == '0) begin
        if (wrap_allow) begin
          count_d  = TOP;
          borrow_d = 1'b1;
        end
      end else begin
        count_d = count_q - BITS'(1);
      end
    end
  end

  assign count_out  = count_q;
  assign borrow_out = borrow_q;
  assign zero_c     = (count_q == '0);

endmodule

// File: rtl/mod_down_timer.sv
// Loadable mod-N down timer: run-control FSM around the count datapath.
module mod_down_timer
  import mod_down_timer_pkg::*;
#(
  parameter int unsigned MOD         = MOD_HOUR,
  parameter int unsigned BITS        = 5,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic           clk,
  input  logic           rst,
  mod_down_timer_if.slave bus
);

  state_e state_q, state_d;
  logic   run_tick_c;
  logic   wrap_allow_c;
  logic   zero_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Priority: clr, then load, then stop over start, then the expiring tick.
  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = ST_IDLE;
    end else if (bus.load) begin
      if (state_q == ST_EXPIRED) state_d = ST_IDLE;
    end else if (bus.stop) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (bus.start && (state_q != ST_RUN)) begin
      state_d = ST_RUN;
    end else if (run_tick_c && zero_c && !wrap_allow_c) begin
      state_d = ST_EXPIRED;
    end
  end

  always_comb begin
    run_tick_c   = (state_q == ST_RUN) && bus.tick && !bus.clr && !bus.load && !bus.stop;
    wrap_allow_c = (AUTO_RELOAD != 0) || !bus.chain_zero;
    bus.running  = (state_q == ST_RUN);
    bus.expired  = (state_q == ST_EXPIRED);
  end

  mod_down_timer_core #(
    .MOD  (MOD),
    .BITS (BITS)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .clr        (bus.clr),
    .load       (bus.load),
    .load_val   (bus.load_val),
    .tick_en    (run_tick_c),
    .wrap_allow (wrap_allow_c),
    .count_out  (bus.count_out),
    .borrow_out (bus.borrow_out),
    .zero_c     (zero_c)
  );

  assign bus.zero = zero_c;

endmodule

// File: tb/tb_mod_down_timer.sv
// Random and directed checks of one-shot and auto-reload mod-24 timers against a behavioural model.
module tb_mod_down_timer;

  localparam int MODV = 24;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_down_timer_if #(.BITS(5)) bus0 ();
  mod_down_timer_if #(.BITS(5)) bus1 ();

  mod_down_timer #(.MOD(24), .BITS(5), .AUTO_RELOAD(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mod_down_timer #(.MOD(24), .BITS(5), .AUTO_RELOAD(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_total = 0;
  int n_bad   = 0;
  int m_cnt [2];
  int m_st  [2];
  int m_bor [2];

  logic       i_tick, i_start, i_stop, i_clr, i_load, i_cz;
  logic [4:0] i_lv;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_st[k] = M_IDLE; m_bor[k] = 0;
    end
  endtask

  // One clock of the timer described directly from its rules.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int old;
      old = m_st[k];
      m_bor[k] = 0;
      if (i_clr) begin
        m_cnt[k] = 0; m_st[k] = M_IDLE;
      end else if (i_load) begin
        m_cnt[k] = (int'(i_lv) > MODV - 1) ? MODV - 1 : int'(i_lv);
        if (old == M_EXP) m_st[k] = M_IDLE;
      end else if (i_stop) begin
        if (old == M_RUN) m_st[k] = M_PAUSE;
      end else begin
        if (i_start && old != M_RUN) m_st[k] = M_RUN;
        if (old == M_RUN && i_tick) begin
          if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
          else if (k == 1 || !i_cz) begin m_cnt[k] = MODV - 1; m_bor[k] = 1; end
          else m_st[k] = M_EXP;
        end
      end
    end
  endtask

  task automatic check_dut(input string p, input int k, input logic [4:0] c, input logic b,
                           input logic z, input logic r, input logic e);
    check({p, "_count"},   32'(c), 32'(m_cnt[k]));
    check({p, "_borrow"},  32'(b), 32'(m_bor[k]));
    check({p, "_zero"},    32'(z), 32'(m_cnt[k] == 0));
    check({p, "_running"}, 32'(r), 32'(m_st[k] == M_RUN));
    check({p, "_expired"}, 32'(e), 32'(m_st[k] == M_EXP));
  endtask

  task automatic check_all();
    check_dut("oneshot", 0, bus0.count_out, bus0.borrow_out, bus0.zero, bus0.running, bus0.expired);
    check_dut("reload",  1, bus1.count_out, bus1.borrow_out, bus1.zero, bus1.running, bus1.expired);
  endtask

  task automatic drive(input logic t, s, p, c, l, input logic [4:0] v, input logic cz);
    i_tick = t; i_start = s; i_stop = p; i_clr = c; i_load = l; i_lv = v; i_cz = cz;
    bus0.tick = t; bus0.start = s; bus0.stop = p; bus0.clr = c; bus0.load = l;
    bus0.load_val = v; bus0.chain_zero = cz;
    bus1.tick = t; bus1.start = s; bus1.stop = p; bus1.clr = c; bus1.load = l;
    bus1.load_val = v; bus1.chain_zero = cz;
  endtask

  task automatic step(input logic t, s, p, c, l, input logic [4:0] v, input logic cz);
    drive(t, s, p, c, l, v, cz);
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 5'd0, 1);
    model_reset();
    #3;
    check_all();
    #4 rst = 1'b1;

    // One-shot countdown from 5 expires on the sixth tick.
    step(0, 0, 0, 0, 1, 5'd5, 1);
    step(0, 1, 0, 0, 0, 5'd0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 5'd0, 1);
    check("t1_expired", 32'(bus0.expired), 32'd1);
    check("t1_count",   32'(bus0.count_out), 32'd0);

    // Load 1 then three ticks: 1,0,23,22 on the reload timer.
    step(0, 0, 0, 1, 0, 5'd0, 1);
    step(0, 0, 0, 0, 1, 5'd1, 1);
    step(0, 1, 0, 0, 0, 5'd0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 5'd0, 1);
    check("t2_count", 32'(bus1.count_out), 32'd22);

    // Higher stages nonzero: one-shot timer wraps instead of expiring.
    step(0, 0, 0, 1, 0, 5'd0, 1);
    step(0, 1, 0, 0, 0, 5'd0, 1);
    step(1, 0, 0, 0, 0, 5'd0, 0);
    check("t3_wrap",   32'(bus0.count_out), 32'd23);
    check("t3_borrow", 32'(bus0.borrow_out), 32'd1);

    // Saturating load and load-over-tick priority.
    step(0, 0, 0, 0, 1, 5'd30, 1);
    check("t4_sat", 32'(bus0.count_out), 32'd23);
    step(1, 0, 0, 0, 1, 5'd10, 1);
    check("t4_load_tick", 32'(bus0.count_out), 32'd10);

    // stop beats start; pause holds; resume counts again.
    step(0, 0, 0, 0, 1, 5'd7, 1);
    step(0, 1, 1, 0, 0, 5'd0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 5'd0, 1);
    step(0, 1, 0, 0, 0, 5'd0, 1);
    step(1, 0, 0, 0, 0, 5'd0, 1);
    check("t5_resume", 32'(bus0.count_out), 32'd6);

    // Asynchronous reset in mid count takes effect before the next edge.
    step(0, 0, 0, 0, 1, 5'd12, 1);
    step(0, 0, 0, 0, 0, 5'd0, 1);
    drive(0, 0, 0, 0, 0, 5'd0, 1);
    #1 rst = 1'b0;
    #1 model_reset();
    check_all();
    #3 rst = 1'b1;

    // clr out of EXPIRED.
    step(0, 0, 0, 0, 1, 5'd1, 1);
    step(0, 1, 0, 0, 0, 5'd0, 1);
    step(1, 0, 0, 0, 0, 5'd0, 1);
    step(1, 0, 0, 0, 0, 5'd0, 1);
    check("t6_expired", 32'(bus0.expired), 32'd1);
    step(0, 0, 0, 1, 0, 5'd0, 1);

    for (int i = 0; i < 3000; i++) begin
      logic t, s, p, c, l, cz;
      t  = ($urandom_range(99, 0) < 60);
      s  = ($urandom_range(99, 0) < 10);
      p  = ($urandom_range(99, 0) < 5);
      c  = ($urandom_range(99, 0) < 2);
      l  = ($urandom_range(99, 0) < 6);
      cz = ($urandom_range(99, 0) < 80);
      step(t, s, p, c, l, 5'($urandom_range(31, 0)), cz);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
